bram_encode_write: RTL and testbench

//  Write-back half of the 8-BU NTT memory path. Takes the per-lane core addresses (plus olen)

---
 rtl/bram_encode_write.sv | 227 ++++++++++++++++++++++
 tb/tb_bram_encode_write.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_encode_write.sv
`default_nettype none
// ============================================================================
// Module   : bram_encode_write
// Purpose  : Write-back half of the 8-BU NTT memory path. Per-lane core
//            addresses (with olen) issued alongside a butterfly read are
//            delayed to match butterfly latency, split into {bank index,
//            bank address}, and used to route the 8 BU result pairs onto the
//            port-A / port-B write ports of the 8 coefficient BRAM banks.
//            A small FSM tracks the stage and pulses done_write_o once the
//            final write of the stage has been issued.
// Ports    : clk_i, rst_i (async, active-low)
//            valid_i, last_i, olen_i, addr_core_i   - address issue side
//            bu_outA_i, bu_outB_i                   - butterfly results
//            wr_en_o/wr_addr_o/wr_data_o            - bank port-A writes
//            wr_en_B_o/wr_addr_B_o/wr_data_B_o      - bank port-B writes
//            busy_o, done_write_o, err_conflict_o   - status
// Config   : WB_CONFLICT_CHK_EN - when defined, same-bank lane collisions at
//            the routing stage set the sticky err_conflict_o flag; when not
//            defined err_conflict_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module bram_encode_write #(
    parameter int DATA_WIDTH = 12,
    parameter int ADW        = 5,
    parameter int BU_LAT     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic                    last_i,
    input  logic [ADW+2:0]          olen_i,
    input  logic [8*(ADW+3)-1:0]    addr_core_i,
    input  logic [8*DATA_WIDTH-1:0] bu_outA_i,
    input  logic [8*DATA_WIDTH-1:0] bu_outB_i,
    output logic [7:0]              wr_en_o,
    output logic [8*ADW-1:0]        wr_addr_o,
    output logic [8*DATA_WIDTH-1:0] wr_data_o,
    output logic [7:0]              wr_en_B_o,
    output logic [8*ADW-1:0]        wr_addr_B_o,
    output logic [8*DATA_WIDTH-1:0] wr_data_B_o,
    output logic                    busy_o,
    output logic                    done_write_o,
    output logic                    err_conflict_o
);

    localparam int NL  = 8;            // lanes == banks
    localparam int CAW = ADW + 3;      // core address width
    localparam int PW  = NL * 2 * CAW; // delay-line payload: A and B core per lane

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    // Delay line. The payload holds the raw core addresses; the bank index
    // and bank address are simply bit fields of them, so no separate decode
    // storage is needed.
    logic [BU_LAT-1:0]         dv_q, dv_d;
    logic [BU_LAT-1:0][PW-1:0] dp_q, dp_d;
    logic [PW-1:0]             in_payload;

    logic [2:0]     rt_idx_a [NL];
    logic [2:0]     rt_idx_b [NL];
    logic [ADW-1:0] rt_adr_a [NL];
    logic [ADW-1:0] rt_adr_b [NL];
    logic           rt_valid;

    logic [7:0]              wr_en_q, wr_en_d;
    logic [8*ADW-1:0]        wr_addr_q, wr_addr_d;
    logic [8*DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [7:0]              wr_en_b_q, wr_en_b_d;
    logic [8*ADW-1:0]        wr_addr_b_q, wr_addr_b_d;
    logic [8*DATA_WIDTH-1:0] wr_data_b_q, wr_data_b_d;

    // Port-B core address wraps modulo the coefficient count (8-bit add).
    for (genvar j = 0; j < NL; j++) begin : g_lane
        assign in_payload[2*CAW*j +: CAW]       = addr_core_i[CAW*j +: CAW];
        assign in_payload[2*CAW*j+CAW +: CAW]   = addr_core_i[CAW*j +: CAW] + olen_i;

        assign rt_idx_a[j] = dp_q[BU_LAT-1][2*CAW*j+CAW-1 -: 3];
        assign rt_adr_a[j] = dp_q[BU_LAT-1][2*CAW*j +: ADW];
        assign rt_idx_b[j] = dp_q[BU_LAT-1][2*CAW*j+2*CAW-1 -: 3];
        assign rt_adr_b[j] = dp_q[BU_LAT-1][2*CAW*j+CAW +: ADW];
    end

    assign rt_valid = dv_q[BU_LAT-1];

    always_comb begin
        dv_d    = dv_q;
        dp_d    = dp_q;
        dv_d[0] = valid_i;
        dp_d[0] = in_payload;
        for (int i = 1; i < BU_LAT; i++) begin
            dv_d[i] = dv_q[i-1];
            dp_d[i] = dp_q[i-1];
        end
    end

    // Routing: walk lanes from highest to lowest so the lowest lane that
    // targets a bank is the last assignment and therefore wins.
    always_comb begin
        wr_en_d     = '0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_b_d   = '0;
        wr_addr_b_d = wr_addr_b_q;
        wr_data_b_d = wr_data_b_q;
        if (rt_valid) begin
            for (int j = NL - 1; j >= 0; j--) begin
                wr_en_d[rt_idx_a[j]]                            = 1'b1;
                wr_addr_d[ADW*rt_idx_a[j] +: ADW]               = rt_adr_a[j];
                wr_data_d[DATA_WIDTH*rt_idx_a[j] +: DATA_WIDTH] = bu_outA_i[DATA_WIDTH*j +: DATA_WIDTH];
                wr_en_b_d[rt_idx_b[j]]                            = 1'b1;
                wr_addr_b_d[ADW*rt_idx_b[j] +: ADW]               = rt_adr_b[j];
                wr_data_b_d[DATA_WIDTH*rt_idx_b[j] +: DATA_WIDTH] = bu_outB_i[DATA_WIDTH*j +: DATA_WIDTH];
            end
        end
    end

    // Stage FSM. valid_i only steers the FSM outside DRAIN; the delay line
    // itself always accepts valid_i since there is no backpressure.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    cnt_d   = 4'd0;
                    state_d = last_i ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (valid_i && last_i) begin
                    cnt_d   = 4'd0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // BU_LAT+1 drain cycles cover the delay line plus the output
                // register, so done lands one cycle after the last strobe.
                if (cnt_q == 4'(BU_LAT)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            dv_q        <= '0;
            dp_q        <= '0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_b_q   <= '0;
            wr_addr_b_q <= '0;
            wr_data_b_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            dv_q        <= dv_d;
            dp_q        <= dp_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_b_q   <= wr_en_b_d;
            wr_addr_b_q <= wr_addr_b_d;
            wr_data_b_q <= wr_data_b_d;
        end
    end

`ifdef WB_CONFLICT_CHK_EN
    logic conflict;
    logic err_q, err_d;

    always_comb begin
        conflict = 1'b0;
        if (rt_valid) begin
            for (int j = 0; j < NL - 1; j++) begin
                for (int l = j + 1; l < NL; l++) begin
                    if ((rt_idx_a[j] == rt_idx_a[l]) || (rt_idx_b[j] == rt_idx_b[l])) begin
                        conflict = 1'b1;
                    end
                end
            end
        end
        err_d = err_q | conflict;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_conflict_o = err_q;
`else
    assign err_conflict_o = 1'b0;
`endif

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign wr_en_B_o    = wr_en_b_q;
    assign wr_addr_B_o  = wr_addr_b_q;
    assign wr_data_B_o  = wr_data_b_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_write_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_encode_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_encode_write
// Purpose  : Directed testbench for bram_encode_write (BU_LAT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_encode_write;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        last;
    logic [7:0]  olen;
    logic [63:0] addr_core;
    logic [95:0] bu_a;
    logic [95:0] bu_b;
    logic [7:0]  wr_en;
    logic [39:0] wr_addr;
    logic [95:0] wr_data;
    logic [7:0]  wr_en_b;
    logic [39:0] wr_addr_b;
    logic [95:0] wr_data_b;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_err;

    always #5 clk = ~clk;

    bram_encode_write #(
        .DATA_WIDTH (12),
        .ADW        (5),
        .BU_LAT     (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .valid_i        (valid),
        .last_i         (last),
        .olen_i         (olen),
        .addr_core_i    (addr_core),
        .bu_outA_i      (bu_a),
        .bu_outB_i      (bu_b),
        .wr_en_o        (wr_en),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .wr_en_B_o      (wr_en_b),
        .wr_addr_B_o    (wr_addr_b),
        .wr_data_B_o    (wr_data_b),
        .busy_o         (busy),
        .done_write_o   (done),
        .err_conflict_o (err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] dat(input int base);
        logic [95:0] r;
        for (int j = 0; j < 8; j++) r[12*j +: 12] = 12'(base + j);
        return r;
    endfunction

    function automatic logic [95:0] rev(input int base);
        logic [95:0] r;
        for (int k = 0; k < 8; k++) r[12*k +: 12] = 12'(base + 7 - k);
        return r;
    endfunction

    function automatic logic [39:0] rep5(input logic [4:0] v);
        logic [39:0] r;
        for (int k = 0; k < 8; k++) r[5*k +: 5] = v;
        return r;
    endfunction

    // Single address set with last at relative cycle 0, results at cycle 4;
    // returns positioned at cycle 5 where the strobes are visible.
    task automatic issue(input logic [63:0] a, input logic [7:0] ol,
                         input logic [95:0] da, input logic [95:0] db);
        addr_core = a;
        olen      = ol;
        valid     = 1'b1;
        last      = 1'b1;
        step();
        valid     = 1'b0;
        last      = 1'b0;
        addr_core = '0;
        olen      = '0;
        step();
        step();
        step();
        bu_a = da;
        bu_b = db;
        step();
        bu_a = '0;
        bu_b = '0;
    endtask

    initial begin
        logic [63:0] a;
        logic [95:0] e;

`ifdef WB_CONFLICT_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        rst_n     = 1'b0;
        valid     = 1'b0;
        last      = 1'b0;
        olen      = '0;
        addr_core = '0;
        bu_a      = '0;
        bu_b      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en",   128'(wr_en),   128'h0);
        check("rst_wr_en_b", 128'(wr_en_b), 128'h0);
        check("rst_wr_data", 128'(wr_data), 128'h0);
        check("rst_busy",    128'(busy),    128'h0);
        check("rst_done",    128'(done),    128'h0);
        check("rst_err",     128'(err),     128'h0);
        rst_n = 1'b1;

        // Test 1: identity mapping, olen 16
        for (int j = 0; j < 8; j++) a[8*j +: 8] = 8'(32 * j);
        issue(a, 8'd16, dat(12'h100), dat(12'h200));
        check("t1_en_a",   128'(wr_en),     128'hFF);
        check("t1_en_b",   128'(wr_en_b),   128'hFF);
        check("t1_addr_a", 128'(wr_addr),   128'(rep5(5'd0)));
        check("t1_addr_b", 128'(wr_addr_b), 128'(rep5(5'd16)));
        check("t1_data_a", 128'(wr_data),   128'(dat(12'h100)));
        check("t1_data_b", 128'(wr_data_b), 128'(dat(12'h200)));
        check("t1_busy",   128'(busy),      128'h1);
        check("t1_done_early", 128'(done),  128'h0);
        step();
        check("t1_done",   128'(done),      128'h1);
        check("t1_en_off", 128'(wr_en),     128'h0);
        check("t1_idle",   128'(busy),      128'h0);
        step();
        check("t1_done_pulse", 128'(done),  128'h0);
        step();

        // Test 2: reversed mapping, olen 1
        for (int j = 0; j < 8; j++) a[8*j +: 8] = 8'(32 * (7 - j) + 3);
        issue(a, 8'd1, dat(12'h500), dat(12'h600));
        check("t2_en_a",   128'(wr_en),     128'hFF);
        check("t2_en_b",   128'(wr_en_b),   128'hFF);
        check("t2_addr_a", 128'(wr_addr),   128'(rep5(5'd3)));
        check("t2_addr_b", 128'(wr_addr_b), 128'(rep5(5'd4)));
        check("t2_data_a", 128'(wr_data),   128'(rev(12'h500)));
        check("t2_data_b", 128'(wr_data_b), 128'(rev(12'h600)));
        step();
        step();

        // Test 3: port-B address wrap on lane 0, other lanes disjoint
        a[7:0] = 8'd250;
        for (int j = 1; j < 8; j++) a[8*j +: 8] = 8'(32 * (j - 1) + 20);
        issue(a, 8'd16, dat(12'h700), dat(12'h780));
        check("t3_en_a",      128'(wr_en),              128'hFF);
        check("t3_en_b",      128'(wr_en_b),            128'hFF);
        check("t3_wrap_addr", 128'(wr_addr_b[4:0]),     128'd10);
        check("t3_wrap_data", 128'(wr_data_b[11:0]),    128'h780);
        check("t3_b7_addr",   128'(wr_addr[39:35]),     128'd26);
        check("t3_b7_data",   128'(wr_data[95:84]),     128'h700);
        check("t3_b0_data",   128'(wr_data[11:0]),      128'h701);
        check("t3_no_err",    128'(err),                128'h0);
        step();
        step();

        // Test 5: ten back-to-back address sets, last on the tenth
        for (int c = 0; c < 20; c++) begin
            check("t5_en_a", 128'(wr_en),   (c >= 5 && c <= 14) ? 128'hFF : 128'h0);
            check("t5_en_b", 128'(wr_en_b), (c >= 5 && c <= 14) ? 128'hFF : 128'h0);
            check("t5_done", 128'(done),    (c == 15) ? 128'h1 : 128'h0);
            check("t5_busy", 128'(busy),    (c >= 1 && c <= 14) ? 128'h1 : 128'h0);
            if (c >= 5 && c <= 14) begin
                check("t5_data_a", 128'(wr_data),   128'(dat((c - 1) * 16)));
                check("t5_data_b", 128'(wr_data_b), 128'(dat((c - 1) * 16 + 12'h800)));
                check("t5_addr_b", 128'(wr_addr_b), 128'(rep5(5'd16)));
            end
            valid = (c <= 9);
            last  = (c == 9);
            olen  = 8'd16;
            for (int j = 0; j < 8; j++) addr_core[8*j +: 8] = 8'(32 * j);
            bu_a = dat(c * 16);
            bu_b = dat(c * 16 + 12'h800);
            step();
        end

        // Test 6: reset asserted at cycle 7 of the same sequence
        for (int c = 0; c < 26; c++) begin
            if (c == 9) rst_n = 1'b1;
            if (c == 7) begin
                rst_n = 1'b0;
                #1;
                check("t6_rst_en_a", 128'(wr_en),     128'h0);
                check("t6_rst_en_b", 128'(wr_en_b),   128'h0);
                check("t6_rst_addr", 128'(wr_addr),   128'h0);
                check("t6_rst_data", 128'(wr_data),   128'h0);
                check("t6_rst_datb", 128'(wr_data_b), 128'h0);
                check("t6_rst_busy", 128'(busy),      128'h0);
                check("t6_rst_done", 128'(done),      128'h0);
            end else if (c < 7) begin
                check("t6_pre_en", 128'(wr_en), (c >= 5) ? 128'hFF : 128'h0);
            end else if (c >= 9) begin
                check("t6_post_en_a", 128'(wr_en),   128'h0);
                check("t6_post_en_b", 128'(wr_en_b), 128'h0);
                check("t6_post_done", 128'(done),    128'h0);
                check("t6_post_busy", 128'(busy),    128'h0);
            end
            valid = (c < 7);
            last  = 1'b0;
            olen  = 8'd16;
            for (int j = 0; j < 8; j++) addr_core[8*j +: 8] = 8'(32 * j);
            bu_a = dat(c * 16);
            bu_b = dat(c * 16 + 12'h800);
            step();
        end
        valid = 1'b0;

        // Test 4: lanes 0 and 1 collide on bank 0; bank 7 untouched
        check("t4_err_before", 128'(err), 128'h0);
        a[7:0]  = 8'd0;
        a[15:8] = 8'd0;
        for (int j = 2; j < 8; j++) a[8*j +: 8] = 8'(32 * (j - 1));
        issue(a, 8'd0, dat(12'h300), dat(12'h400));
        e = '0;
        e[11:0] = 12'h300;
        for (int k = 1; k < 7; k++) e[12*k +: 12] = 12'(12'h300 + k + 1);
        check("t4_en_a",    128'(wr_en),          128'h7F);
        check("t4_en_b",    128'(wr_en_b),        128'h7F);
        check("t4_data_a",  128'(wr_data),        128'(e));
        check("t4_b7_hold", 128'(wr_addr[39:35]), 128'h0);
        check("t4_err",     128'(err),            128'(exp_err));
        step();
        step();
        step();
        check("t4_err_sticky", 128'(err),         128'(exp_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
